iter_multiplier: RTL and testbench

Multi-cycle, parametrised multiply/multiply-accumulate unit for the EX stage, the successor to the single-cycle combinational multiplier. It computes signed/unsigned products with optional HI/LO accumulate or subtract, retiring RADIX_BITS multiplier bits per cycle so the multiply no longer sits on the EX critical path. It holds the pipeline through a stall request and can be cancelled by an exception flush.

---
 rtl/iter_multiplier_pkg.sv | 29 ++
 rtl/iter_multiplier_if.sv | 27 ++
 rtl/iter_multiplier_mul_radix_step.sv | 30 +++
 rtl/iter_multiplier.sv | 141 ++++++++++++++
 tb/tb_iter_multiplier.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/iter_multiplier_pkg.sv
// Shared definitions for the iterative multiply/MAC unit: op codes, FSM states
// and width helpers.
package iter_multiplier_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int MUL_OP_W           = 3;

   localparam logic [MUL_OP_W-1:0] MUL_OP_MULT  = 3'd0;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MULTU = 3'd1;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MADD  = 3'd2;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MADDU = 3'd3;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MSUB  = 3'd4;
   localparam logic [MUL_OP_W-1:0] MUL_OP_MSUBU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   function automatic int dbl_width(input int w);
      return 2 * w;
   endfunction

   function automatic logic op_is_signed(input logic [MUL_OP_W-1:0] op);
      return (op == MUL_OP_MULT) || (op == MUL_OP_MADD) || (op == MUL_OP_MSUB);
   endfunction

endpackage

// File: rtl/iter_multiplier_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
interface iter_multiplier_if #(parameter int DATA_WIDTH = 32);
   import iter_multiplier_pkg::*;

   logic                      start;
   logic [MUL_OP_W-1:0]       op;
   logic [DATA_WIDTH-1:0]     operand_1;
   logic [DATA_WIDTH-1:0]     operand_2;
   logic [DATA_WIDTH-1:0]     hi_in;
   logic [DATA_WIDTH-1:0]     lo_in;
   logic                      cancel;
   logic                      stall_req;
   logic                      busy;
   logic                      done;
   logic [2*DATA_WIDTH-1:0]   result;

   modport master (
      output start, op, operand_1, operand_2, hi_in, lo_in, cancel,
      input  stall_req, busy, done, result
   );

   modport slave (
      input  start, op, operand_1, operand_2, hi_in, lo_in, cancel,
      output stall_req, busy, done, result
   );

endinterface

// File: rtl/iter_multiplier_mul_radix_step.sv
// One iteration of the shift-and-add multiply: adds mcand * digit, shifted to
// the digit's position, into the 2W-bit partial product. Purely combinational.
module mul_radix_step
   import iter_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RADIX_BITS = 2,
   parameter int CNT_W      = 4
) (
   input  logic [dbl_width(DATA_WIDTH)-1:0] partial_in,
   input  logic [DATA_WIDTH-1:0]            mcand,
   input  logic [RADIX_BITS-1:0]            mplier_bits,
   input  logic [CNT_W-1:0]                 count,
   output logic [dbl_width(DATA_WIDTH)-1:0] partial_out
);

   localparam int PW         = dbl_width(DATA_WIDTH);
   localparam int RADIX_LOG2 = $clog2(RADIX_BITS);

   logic [DATA_WIDTH+RADIX_BITS-1:0] digit_prod;
   logic [PW-1:0]                    digit_ext;
   logic [CNT_W+2:0]                 shamt;

   // RADIX_BITS is a power of two, so the digit position is a plain shift of count
   assign shamt       = (CNT_W+3)'(count) << RADIX_LOG2;
   assign digit_prod  = {{RADIX_BITS{1'b0}}, mcand} * {{DATA_WIDTH{1'b0}}, mplier_bits};
   assign digit_ext   = {{(PW-DATA_WIDTH-RADIX_BITS){1'b0}}, digit_prod} << shamt;
   assign partial_out = partial_in + digit_ext;

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle signed/unsigned multiply with HI/LO accumulate/subtract, retiring
// RADIX_BITS multiplier bits per cycle. Cancellable; result held between ops.
module iter_multiplier
   import iter_multiplier_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RADIX_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   iter_multiplier_if.slave bus
);

   localparam int PW     = dbl_width(DATA_WIDTH);
   localparam int N_ITER = DATA_WIDTH / RADIX_BITS;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

   mul_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic                  neg_q, neg_d;
   logic [MUL_OP_W-1:0]   op_q, op_d;
   logic [PW-1:0]         acc_q, acc_d;
   logic [PW-1:0]         partial_q, partial_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [PW-1:0]         result_q, result_d;

   logic [PW-1:0]         step_sum;
   logic [PW-1:0]         prod_final;
   logic [DATA_WIDTH-1:0] mag_1, mag_2;
   logic                  is_signed;
   logic                  accept;

   mul_radix_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .RADIX_BITS (RADIX_BITS),
      .CNT_W      (CNT_W)
   ) u_step (
      .partial_in  (partial_q),
      .mcand       (mcand_q),
      .mplier_bits (mplier_q[RADIX_BITS-1:0]),
      .count       (count_q),
      .partial_out (step_sum)
   );

   always_comb begin
      is_signed = op_is_signed(bus.op);
      // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
      mag_1 = (is_signed && bus.operand_1[DATA_WIDTH-1]) ? -bus.operand_1 : bus.operand_1;
      mag_2 = (is_signed && bus.operand_2[DATA_WIDTH-1]) ? -bus.operand_2 : bus.operand_2;
      accept     = (state_q == ST_IDLE) && bus.start && !bus.cancel;
      prod_final = neg_q ? -step_sum : step_sum;
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      neg_d     = neg_q;
      op_d      = op_q;
      acc_d     = acc_q;
      partial_d = partial_q;
      count_d   = count_q;
      result_d  = result_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mcand_d   = mag_1;
               mplier_d  = mag_2;
               neg_d     = is_signed && (bus.operand_1[DATA_WIDTH-1] ^ bus.operand_2[DATA_WIDTH-1]);
               op_d      = bus.op;
               acc_d     = {bus.hi_in, bus.lo_in};
               partial_d = '0;
               count_d   = '0;
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            if (bus.cancel) begin
               state_d = ST_IDLE;
            end else begin
               partial_d = step_sum;
               mplier_d  = mplier_q >> RADIX_BITS;
               count_d   = count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
                  state_d = ST_DONE;
                  case (op_q)
                     MUL_OP_MADD, MUL_OP_MADDU: result_d = acc_q + prod_final;
                     MUL_OP_MSUB, MUL_OP_MSUBU: result_d = acc_q - prod_final;
                     default:                   result_d = prod_final;
                  endcase
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         neg_q     <= 1'b0;
         op_q      <= '0;
         acc_q     <= '0;
         partial_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         neg_q     <= neg_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         partial_q <= partial_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   // stall_req is low in DONE so the instruction advances together with result
   assign bus.stall_req = accept || (state_q == ST_CALC);
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Drives three multipliers (RADIX_BITS 1/2/4) with identical stimulus and
// checks timing, control outputs and results against a 64-bit reference.
module tb_iter_multiplier;
   import iter_multiplier_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           start;
   logic           cancel;
   logic [2:0]     op;
   logic [W-1:0]   opa, opb, hi, lo;

   logic           done_w  [3];
   logic           busy_w  [3];
   logic           stall_w [3];
   logic [2*W-1:0] res_w   [3];

   logic [2*W-1:0] sb [3][$];
   logic [2*W-1:0] last_res [3];

   int n_cmp = 0;
   int n_bad = 0;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      iter_multiplier_if #(.DATA_WIDTH(W)) bus ();
      assign bus.start     = start;
      assign bus.op        = op;
      assign bus.operand_1 = opa;
      assign bus.operand_2 = opb;
      assign bus.hi_in     = hi;
      assign bus.lo_in     = lo;
      assign bus.cancel    = cancel;
      assign done_w[i]     = bus.done;
      assign busy_w[i]     = bus.busy;
      assign stall_w[i]    = bus.stall_req;
      assign res_w[i]      = bus.result;

      iter_multiplier #(.DATA_WIDTH(W), .RADIX_BITS(1 << i)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] h, input logic [31:0] l);
      logic [63:0] p, acc;
      acc = {h, l};
      if (o == MUL_OP_MULT || o == MUL_OP_MADD || o == MUL_OP_MSUB)
         p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      else
         p = {32'b0, x} * {32'b0, y};
      case (o)
         MUL_OP_MADD, MUL_OP_MADDU: return acc + p;
         MUL_OP_MSUB, MUL_OP_MSUBU: return acc - p;
         default:                   return p;
      endcase
   endfunction

   // Entered and left at a negedge. Cycle 0 has start high; cycle c is sampled
   // at the negedge inside it. cancel_at/rst_at/restart_at < 0 means unused.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] h, input logic [31:0] l,
                         input int cancel_at, input int rst_at, input int restart_at);
      logic [63:0] exp_r;
      int          ab_at;
      exp_r = model(o, x, y, h, l);
      ab_at = (cancel_at >= 0) ? cancel_at : rst_at;
      if (ab_at < 0)
         for (int k = 0; k < 3; k++) sb[k].push_back(exp_r);
      start = 1'b1; op = o; opa = x; opb = y; hi = h; lo = l;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s r%0d c0 stall", nm, 1 << k), 64'(stall_w[k]), 64'd1);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         for (int k = 0; k < 3; k++) begin
            int n;
            bit live;
            logic [63:0] e;
            n    = 32 >> k;
            live = (ab_at < 0) || (c <= ab_at);
            chk($sformatf("%s r%0d c%0d done", nm, 1 << k, c), 64'(done_w[k]), 64'(live && c == n + 1));
            chk($sformatf("%s r%0d c%0d busy", nm, 1 << k, c), 64'(busy_w[k]), 64'(live && c <= n + 1));
            chk($sformatf("%s r%0d c%0d stall", nm, 1 << k, c), 64'(stall_w[k]), 64'(live && c <= n));
            if (live && c == n + 1) begin
               if (sb[k].size() == 0) begin
                  chk($sformatf("%s r%0d scoreboard empty", nm, 1 << k), 64'(sb[k].size()), 64'd1);
               end else begin
                  e = sb[k].pop_front();
                  chk($sformatf("%s r%0d result", nm, 1 << k), res_w[k], e);
                  last_res[k] = e;
               end
            end
            if (ab_at >= 0 && c == ab_at + 1) begin
               if (rst_at >= 0) last_res[k] = '0;
               chk($sformatf("%s r%0d result after abort", nm, 1 << k), res_w[k], last_res[k]);
            end
         end
         rst    = (c == rst_at);
         cancel = (c == cancel_at);
         start  = (c == restart_at);
         if (c == restart_at) begin
            op = MUL_OP_MULTU; opa = $urandom; opb = $urandom; hi = $urandom; lo = $urandom;
         end
         @(negedge clk);
      end
      rst = 1'b0; cancel = 1'b0; start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0;
      opa = '0; opb = '0; hi = '0; lo = '0;
      for (int k = 0; k < 3; k++) last_res[k] = '0;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset r%0d busy", 1 << k), 64'(busy_w[k]), 64'd0);
         chk($sformatf("reset r%0d done", 1 << k), 64'(done_w[k]), 64'd0);
         chk($sformatf("reset r%0d result", 1 << k), res_w[k], 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_op("mult_m1x2",  MUL_OP_MULT,  32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, -1, -1, -1);
      run_op("multu_m1x2", MUL_OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, -1, -1, -1);
      run_op("mult_min",   MUL_OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0, -1, -1, -1);
      run_op("madd",       MUL_OP_MADD,  32'd3, 32'hFFFFFFFE, 32'h0, 32'h10, -1, -1, -1);
      run_op("msubu",      MUL_OP_MSUBU, 32'd1, 32'd1, 32'h0, 32'h0, -1, -1, -1);
      // expected values for the directed cases above, independent of the model
      chk("const mult_m1x2",  model(MUL_OP_MULT,  32'hFFFFFFFF, 32'h2, 0, 0), 64'hFFFFFFFF_FFFFFFFE);
      chk("const multu_m1x2", model(MUL_OP_MULTU, 32'hFFFFFFFF, 32'h2, 0, 0), 64'h00000001_FFFFFFFE);
      chk("const mult_min",   model(MUL_OP_MULT,  32'h80000000, 32'h80000000, 0, 0), 64'h40000000_00000000);
      chk("const madd",       model(MUL_OP_MADD,  32'd3, 32'hFFFFFFFE, 0, 32'h10), 64'h00000000_0000000A);
      chk("const msubu",      model(MUL_OP_MSUBU, 32'd1, 32'd1, 0, 0), 64'hFFFFFFFF_FFFFFFFF);

      run_op("cancel",      MUL_OP_MULT,  32'h1234, 32'h5678, 32'h0, 32'h0, 5, -1, -1);
      run_op("after_cancel", MUL_OP_MADDU, 32'hDEADBEEF, 32'h0BADF00D, 32'h11, 32'h22, -1, -1, -1);

      // start together with cancel in IDLE is not accepted
      start = 1'b1; cancel = 1'b1; op = MUL_OP_MULT; opa = 32'd7; opb = 32'd9;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("idle_cancel r%0d stall", 1 << k), 64'(stall_w[k]), 64'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("idle_cancel r%0d busy", 1 << k), 64'(busy_w[k]), 64'd0);
         chk($sformatf("idle_cancel r%0d done", 1 << k), 64'(done_w[k]), 64'd0);
      end
      start = 1'b0; cancel = 1'b0;
      @(negedge clk);

      run_op("reset_mid", MUL_OP_MSUB, 32'hCAFEF00D, 32'h13579BDF, 32'h1, 32'h2, -1, 8, -1);
      run_op("start_busy", MUL_OP_MSUB, 32'h7FFFFFFF, 32'h80000001, 32'h89ABCDEF, 32'h01234567, -1, -1, 3);

      for (int i = 0; i < 1000; i++) begin
         logic [2:0]  o;
         logic [31:0] x, y;
         o = 3'($urandom_range(0, 5));
         x = $urandom;
         y = $urandom;
         if (i % 16 == 0) x = 32'h80000000;
         if (i % 16 == 1) y = 32'hFFFFFFFF;
         if (i % 16 == 2) y = 32'h0;
         run_op($sformatf("rand%0d", i), o, x, y, $urandom, $urandom, -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
